spi_master: RTL and testbench

- SPI mode-0 initiator that drives the far end of the link served by our spiifc slave.
- On Start, asserts SPI_SS, streams ByteCount bytes MSB-first from a transmit memory onto SPI_MOSI, and captures the same number of bytes from SPI_MISO into a receive memory.
- Sits in the host-side/test FPGA fabric and replaces hand-driven SPI stimulus with a memory-backed, clock-divided engine.

---
 rtl/spi_master.sv | 166 ++++++++++++++++
 tb/tb_spi_master.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI mode-0 initiator: streams ByteCount bytes from a tx memory onto SPI_MOSI
// and writes the bytes captured from SPI_MISO into a receive memory.
module spi_master #(
   parameter int unsigned CLK_DIV    = 2,
   parameter int unsigned ADDR_WIDTH = 12
) (
   input  logic                  SysClk,
   input  logic                  Reset,
   input  logic                  Start,
   input  logic [ADDR_WIDTH:0]   ByteCount,
   output logic                  Busy,
   output logic                  Done,
   output logic                  SPI_CLK,
   output logic                  SPI_MOSI,
   input  logic                  SPI_MISO,
   output logic                  SPI_SS,
   output logic [ADDR_WIDTH-1:0] txMemAddr,
   input  logic [7:0]            txMemData,
   output logic [ADDR_WIDTH-1:0] rcMemAddr,
   output logic [7:0]            rcMemData,
   output logic                  rcMemWE
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      LOW,
      HIGH,
      TAIL,
      FINISH
   } state_t;

   localparam logic [ADDR_WIDTH:0]   MAX_BYTES = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [7:0]            DIV_LAST  = 8'(CLK_DIV - 1);

   state_t                state;
   logic [7:0]            divCnt;
   logic [2:0]            bitCnt;
   logic [ADDR_WIDTH:0]   byteCnt;
   logic [6:0]            txShift;
   logic [7:0]            rxShift;
   logic                  divDone;

   assign divDone = (divCnt == DIV_LAST);

   always_ff @(posedge SysClk or negedge Reset) begin
      if (!Reset) begin
         state     <= IDLE;
         divCnt    <= '0;
         bitCnt    <= '0;
         byteCnt   <= '0;
         txShift   <= '0;
         rxShift   <= '0;
         Busy      <= 1'b0;
         Done      <= 1'b0;
         SPI_CLK   <= 1'b0;
         SPI_MOSI  <= 1'b0;
         SPI_SS    <= 1'b1;
         txMemAddr <= '0;
         rcMemAddr <= '0;
         rcMemData <= '0;
         rcMemWE   <= 1'b0;
      end else begin
         Done    <= 1'b0;
         rcMemWE <= 1'b0;
         // The write address advances the cycle after its strobe.
         if (rcMemWE) begin
            rcMemAddr <= rcMemAddr + ADDR_ONE;
         end

         case (state)
            IDLE: begin
               if (Start) begin
                  if (ByteCount == '0) begin
                     Done <= 1'b1;
                  end else begin
                     byteCnt   <= (ByteCount > MAX_BYTES) ? MAX_BYTES : ByteCount;
                     txMemAddr <= '0;
                     rcMemAddr <= '0;
                     Busy      <= 1'b1;
                     state     <= FETCH;
                  end
               end
            end

            FETCH: begin
               state <= LOAD;
            end

            LOAD: begin
               txShift   <= txMemData[6:0];
               SPI_MOSI  <= txMemData[7];
               SPI_SS    <= 1'b0;
               txMemAddr <= txMemAddr + ADDR_ONE;
               bitCnt    <= '0;
               divCnt    <= '0;
               state     <= LOW;
            end

            LOW: begin
               if (divDone) begin
                  SPI_CLK <= 1'b1;
                  rxShift <= {rxShift[6:0], SPI_MISO};
                  divCnt  <= '0;
                  state   <= HIGH;
               end else begin
                  divCnt <= divCnt + 8'd1;
               end
            end

            HIGH: begin
               if (divDone) begin
                  SPI_CLK <= 1'b0;
                  divCnt  <= '0;
                  bitCnt  <= bitCnt + 3'd1;
                  if (bitCnt != 3'd7) begin
                     SPI_MOSI <= txShift[6];
                     txShift  <= {txShift[5:0], 1'b0};
                     state    <= LOW;
                  end else begin
                     rcMemWE   <= 1'b1;
                     rcMemData <= rxShift;
                     byteCnt   <= byteCnt - CNT_ONE;
                     // Next byte was prefetched during LOAD / the previous byte.
                     if (byteCnt != CNT_ONE) begin
                        txShift   <= txMemData[6:0];
                        SPI_MOSI  <= txMemData[7];
                        txMemAddr <= txMemAddr + ADDR_ONE;
                        state     <= LOW;
                     end else begin
                        state <= TAIL;
                     end
                  end
               end else begin
                  divCnt <= divCnt + 8'd1;
               end
            end

            TAIL: begin
               if (divDone) begin
                  SPI_SS <= 1'b1;
                  Done   <= 1'b1;
                  divCnt <= '0;
                  state  <= FINISH;
               end else begin
                  divCnt <= divCnt + 8'd1;
               end
            end

            FINISH: begin
               Busy     <= 1'b0;
               SPI_MOSI <= 1'b0;
               state    <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: table vectors, randomized transfers and
// hand-written corner sequences, checked against a byte-level SPI slave model.
module tb_spi_master;

   localparam int unsigned AW   = 4;
   localparam int          MAXB = 16;

   logic        SysClk = 1'b0;
   logic        Reset;
   logic        startReq;
   logic [AW:0] byteCount;
   int          sel;
   logic        miso;

   logic [7:0]  txMem [16];
   logic [7:0]  misoBytes [32];

   logic          startA, busyA, doneA, clkA, mosiA, ssA, weA;
   logic [AW-1:0] txAddrA, rcAddrA;
   logic [7:0]    txDataA, rcDataA;
   logic          startB, busyB, doneB, clkB, mosiB, ssB, weB;
   logic [AW-1:0] txAddrB, rcAddrB;
   logic [7:0]    txDataB, rcDataB;

   logic          mBusy, mDone, mClk, mMosi, mSS, mWe;
   logic [AW-1:0] mRcAddr;
   logic [7:0]    mRcData;

   always #5 SysClk = ~SysClk;

   spi_master #(.CLK_DIV(2), .ADDR_WIDTH(AW)) dutA (
      .SysClk(SysClk), .Reset(Reset), .Start(startA), .ByteCount(byteCount),
      .Busy(busyA), .Done(doneA), .SPI_CLK(clkA), .SPI_MOSI(mosiA),
      .SPI_MISO(miso), .SPI_SS(ssA), .txMemAddr(txAddrA), .txMemData(txDataA),
      .rcMemAddr(rcAddrA), .rcMemData(rcDataA), .rcMemWE(weA)
   );

   spi_master #(.CLK_DIV(1), .ADDR_WIDTH(AW)) dutB (
      .SysClk(SysClk), .Reset(Reset), .Start(startB), .ByteCount(byteCount),
      .Busy(busyB), .Done(doneB), .SPI_CLK(clkB), .SPI_MOSI(mosiB),
      .SPI_MISO(miso), .SPI_SS(ssB), .txMemAddr(txAddrB), .txMemData(txDataB),
      .rcMemAddr(rcAddrB), .rcMemData(rcDataB), .rcMemWE(weB)
   );

   assign startA  = startReq & (sel == 0);
   assign startB  = startReq & (sel != 0);
   assign mBusy   = (sel == 0) ? busyA   : busyB;
   assign mDone   = (sel == 0) ? doneA   : doneB;
   assign mClk    = (sel == 0) ? clkA    : clkB;
   assign mMosi   = (sel == 0) ? mosiA   : mosiB;
   assign mSS     = (sel == 0) ? ssA     : ssB;
   assign mWe     = (sel == 0) ? weA     : weB;
   assign mRcAddr = (sel == 0) ? rcAddrA : rcAddrB;
   assign mRcData = (sel == 0) ? rcDataA : rcDataB;

   always @(posedge SysClk) begin
      txDataA <= txMem[txAddrA];
      txDataB <= txMem[txAddrB];
   end

   // ---------------- monitor / slave model state ----------------
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int startCyc, ssFallCyc, ssRiseCyc, doneCyc, lastEdgeCyc;
   int doneCnt, riseCnt, phaseErr, togSS, togClk, togMosi, busyCnt, busyAtDone;
   int curDiv, bitIdx, slaveBits;
   logic       pSS = 1'b1, pClk = 1'b0, pMosi = 1'b0;
   logic [7:0] slaveShift;
   logic [7:0] slaveRx [$];
   logic [AW-1:0] wrAddr [$];
   logic [7:0]    wrData [$];

   function automatic logic misoBit(input int idx);
      logic [7:0] b;
      if (idx >= 256) return 1'b0;
      b = misoBytes[5'(idx / 8)];
      return b[3'(7 - (idx % 8))];
   endfunction

   function automatic int modelN(input int bc);
      return (bc > MAXB) ? MAXB : bc;
   endfunction

   function automatic int modelSsLow(input int s, input int n);
      int d;
      d = (s == 0) ? 2 : 1;
      return (n == 0) ? 0 : 16 * d * n + d;
   endfunction

   task automatic monitorStep();
      cyc++;
      if (startReq && !mBusy) startCyc = cyc;
      if (mBusy) busyCnt++;
      if (mSS !== pSS) togSS++;
      if (mClk !== pClk) togClk++;
      if (mMosi !== pMosi) togMosi++;
      if (pSS && !mSS) begin
         ssFallCyc   = cyc;
         lastEdgeCyc = cyc;
         bitIdx      = 0;
         slaveBits   = 0;
         miso        = misoBit(0);
      end
      if (!pSS && mSS) ssRiseCyc = cyc;
      if (!pClk && mClk) begin
         riseCnt++;
         if (cyc - lastEdgeCyc != curDiv) phaseErr++;
         lastEdgeCyc = cyc;
         slaveShift  = {slaveShift[6:0], mMosi};
         slaveBits++;
         if (slaveBits == 8) begin
            slaveRx.push_back(slaveShift);
            slaveBits = 0;
         end
      end
      if (pClk && !mClk) begin
         if (cyc - lastEdgeCyc != curDiv) phaseErr++;
         lastEdgeCyc = cyc;
         bitIdx++;
         miso = misoBit(bitIdx);
      end
      if (mWe) begin
         wrAddr.push_back(mRcAddr);
         wrData.push_back(mRcData);
      end
      if (mDone) begin
         doneCnt++;
         doneCyc    = cyc;
         busyAtDone = int'(mBusy);
      end
      pSS   = mSS;
      pClk  = mClk;
      pMosi = mMosi;
   endtask

   initial begin
      forever begin
         @(negedge SysClk);
         monitorStep();
      end
   end

   // ---------------- helpers ----------------
   task automatic step();
      @(posedge SysClk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic clearMon();
      doneCnt = 0; riseCnt = 0; phaseErr = 0; busyCnt = 0; busyAtDone = 0;
      togSS = 0; togClk = 0; togMosi = 0; slaveBits = 0; bitIdx = 0;
      startCyc = -100; ssFallCyc = -100; ssRiseCyc = -100; doneCyc = -100;
      lastEdgeCyc = 0;
      curDiv = (sel == 0) ? 2 : 1;
      slaveRx.delete();
      wrAddr.delete();
      wrData.delete();
   endtask

   task automatic fillData(input bit useHead, input logic [23:0] head, input logic [7:0] rx0);
      for (int i = 0; i < 16; i++) txMem[i] = 8'($urandom);
      for (int i = 0; i < 32; i++) misoBytes[i] = 8'($urandom);
      if (useHead) begin
         txMem[0]     = head[23:16];
         txMem[1]     = head[15:8];
         txMem[2]     = head[7:0];
         misoBytes[0] = rx0;
      end
   endtask

   task automatic startXfer(input int s, input int bc);
      logic [31:0] bcv;
      bcv       = 32'(bc);
      sel       = s;
      clearMon();
      byteCount = bcv[AW:0];
      startReq  = 1'b1;
      step();
      startReq  = 1'b0;
   endtask

   task automatic finishXfer(input int expN, input int expSsLow, input string tag);
      int guard;
      guard = 0;
      while (doneCnt == 0 && guard < 3000) begin
         step();
         guard++;
      end
      repeat (4) step();
      check({tag, " done count"}, doneCnt, 1);
      check({tag, " busy idle"}, int'(mBusy), 0);
      check({tag, " ss idle"}, int'(mSS), 1);
      check({tag, " sclk idle"}, int'(mClk), 0);
      check({tag, " mosi idle"}, int'(mMosi), 0);
      check({tag, " write count"}, wrAddr.size(), expN);
      if (expN == 0) begin
         check({tag, " done latency"}, doneCyc - startCyc, 1);
         check({tag, " pin toggles"}, togSS + togClk + togMosi, 0);
         check({tag, " busy cycles"}, busyCnt, 0);
      end else begin
         check({tag, " start to ss fall"}, ssFallCyc - startCyc, 3);
         check({tag, " ss low"}, ssRiseCyc - ssFallCyc, expSsLow);
         check({tag, " sclk rises"}, riseCnt, 8 * expN);
         check({tag, " phase length errs"}, phaseErr, 0);
         check({tag, " done at ss rise"}, doneCyc, ssRiseCyc);
         check({tag, " busy at done"}, busyAtDone, 1);
         check({tag, " busy cycles"}, busyCnt, expSsLow + 3);
         check({tag, " slave byte count"}, slaveRx.size(), expN);
         for (int i = 0; i < expN; i++) begin
            if (i < slaveRx.size())
               check($sformatf("%s mosi byte %0d", tag, i), int'(slaveRx[i]), int'(txMem[4'(i)]));
            if (i < wrAddr.size()) begin
               check($sformatf("%s rc addr %0d", tag, i), int'(wrAddr[i]), i % 16);
               check($sformatf("%s rc data %0d", tag, i), int'(wrData[i]), int'(misoBytes[5'(i)]));
            end
         end
      end
   endtask

   typedef struct {
      int          sel;
      int          bc;
      bit          useHead;
      logic [23:0] head;
      logic [7:0]  rx0;
      int          expN;
      int          expSsLow;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int guard;

      vecs[0] = '{0,  1, 1'b1, 24'hA5_00_00, 8'h3C,  1,  34};
      vecs[1] = '{0,  3, 1'b1, 24'h01_80_FF, 8'h5A,  3,  98};
      vecs[2] = '{1,  2, 1'b0, 24'h00_00_00, 8'h00,  2,  33};
      vecs[3] = '{0,  0, 1'b0, 24'h00_00_00, 8'h00,  0,   0};
      vecs[4] = '{0, 16, 1'b0, 24'h00_00_00, 8'h00, 16, 514};
      vecs[5] = '{0, 31, 1'b0, 24'h00_00_00, 8'h00, 16, 514};
      vecs[6] = '{1, 17, 1'b0, 24'h00_00_00, 8'h00, 16, 257};
      vecs[7] = '{1,  0, 1'b0, 24'h00_00_00, 8'h00,  0,   0};

      sel       = 0;
      Reset     = 1'b0;
      startReq  = 1'b0;
      byteCount = '0;
      miso      = 1'b0;
      fillData(1'b0, 24'h0, 8'h0);
      clearMon();
      repeat (3) step();

      check("reset ss", int'(ssA), 1);
      check("reset sclk", int'(clkA), 0);
      check("reset mosi", int'(mosiA), 0);
      check("reset busy", int'(busyA), 0);
      check("reset done", int'(doneA), 0);
      check("reset we", int'(weA), 0);
      check("reset txaddr", int'(txAddrA), 0);
      check("reset rcaddr", int'(rcAddrA), 0);
      check("reset rcdata", int'(rcDataA), 0);
      check("reset ss div1", int'(ssB), 1);

      Reset = 1'b1;
      repeat (2) step();

      for (int v = 0; v < 8; v++) begin
         fillData(vecs[v].useHead, vecs[v].head, vecs[v].rx0);
         startXfer(vecs[v].sel, vecs[v].bc);
         finishXfer(vecs[v].expN, vecs[v].expSsLow, $sformatf("vec%0d", v));
      end

      for (int k = 0; k < 8; k++) begin
         int s, bc;
         s  = int'($urandom_range(0, 1));
         bc = int'($urandom_range(0, 20));
         fillData(1'b0, 24'h0, 8'h0);
         startXfer(s, bc);
         finishXfer(modelN(bc), modelSsLow(s, modelN(bc)), $sformatf("rnd%0d", k));
      end

      // Start re-pulsed with a different count mid-transfer
      fillData(1'b0, 24'h0, 8'h0);
      startXfer(0, 2);
      repeat (20) step();
      byteCount = 5'd5;
      startReq  = 1'b1;
      step();
      startReq  = 1'b0;
      finishXfer(2, 66, "repulse");

      // Start coinciding with Done
      fillData(1'b0, 24'h0, 8'h0);
      startXfer(0, 1);
      guard = 0;
      while (mDone !== 1'b1 && guard < 500) begin
         step();
         guard++;
      end
      check("doneStart busy in done cycle", int'(mBusy), 1);
      byteCount = 5'd3;
      startReq  = 1'b1;
      step();
      startReq  = 1'b0;
      repeat (10) step();
      check("doneStart busy after", int'(mBusy), 0);
      check("doneStart done count", doneCnt, 1);
      check("doneStart ss toggles", togSS, 2);
      check("doneStart sclk rises", riseCnt, 8);

      // Reset in the middle of byte 0
      fillData(1'b0, 24'h0, 8'h0);
      startXfer(0, 2);
      guard = 0;
      while (riseCnt < 4 && guard < 500) begin
         step();
         guard++;
      end
      check("midReset reached bit 4", riseCnt, 4);
      #2 Reset = 1'b0;
      #1;
      check("midReset ss", int'(mSS), 1);
      check("midReset sclk", int'(mClk), 0);
      check("midReset busy", int'(mBusy), 0);
      check("midReset we", int'(mWe), 0);
      repeat (3) step();
      Reset = 1'b1;
      repeat (3) step();
      check("midReset writes", wrAddr.size(), 0);
      check("midReset done", doneCnt, 0);
      fillData(1'b0, 24'h0, 8'h0);
      startXfer(0, 1);
      finishXfer(1, 34, "postReset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach its end, errors so far %0d", errors);
      $fatal(1, "watchdog expired");
   end

endmodule
